// File: rtl/fmc120_cpld_i2c_responder.sv
// I2C target for the FMC120 CPLD I2C-to-SPI bridge. It holds a 16x8 register file.
// A write to register 0x0 launches an SPI request built from registers 0x8/0x7/0x6.
module fmc120_cpld_i2c_responder #(
    parameter logic [6:0] DEVADDR     = 7'h1c,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        spi_stb,
    output logic [7:0]  spi_action,
    output logic [23:0] spi_data,
    output logic        reg_wr_stb,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl;
    logic                   sda;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   sda_rise;
    logic                   sda_fall;
    logic                   start_cond;
    logic                   stop_cond;
    logic                   byte_done;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  out_byte;
    logic [3:0]  pointer;
    logic        rw;
    logic        ack_seen;
    logic [7:0]  regs [16];

    assign scl        = scl_sync[SYNC_STAGES-1];
    assign sda        = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl & ~scl_prev;
    assign scl_fall   = ~scl & scl_prev;
    assign sda_rise   = sda & ~sda_prev;
    assign sda_fall   = ~sda & sda_prev;
    assign start_cond = sda_fall & scl;
    assign stop_cond  = sda_rise & scl;
    assign byte_done  = scl_fall & (bit_cnt == 4'd8);

    // Pad synchronizers and previous-value registers; they reset to the idle-high bus level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl;
            sda_prev <= sda;
        end
    end

    // Protocol FSM, register file and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            out_byte   <= 8'h00;
            pointer    <= 4'd0;
            rw         <= 1'b0;
            ack_seen   <= 1'b0;
            sda_oe     <= 1'b0;
            spi_stb    <= 1'b0;
            spi_action <= 8'h00;
            spi_data   <= 24'h000000;
            reg_wr_stb <= 1'b0;
            reg_addr   <= 4'd0;
            reg_wdata  <= 8'h00;
            busy       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            spi_stb    <= 1'b0;
            reg_wr_stb <= 1'b0;
            if (start_cond) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_cond) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                if (scl_rise && (state == ADDR || state == PTR || state == WDATA || state == RDATA)) begin
                    shift   <= {shift[6:0], sda};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    IDLE: begin
                        bit_cnt <= 4'd0;
                    end
                    ADDR: begin
                        if (byte_done) begin
                            if (shift[7:1] == DEVADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shift[0];
                                state  <= ADDR_ACK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                out_byte <= regs[pointer];
                                sda_oe   <= ~regs[pointer][7];
                                state    <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (byte_done) begin
                            pointer <= shift[3:0];
                            sda_oe  <= 1'b1;
                            state   <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (byte_done) begin
                            regs[pointer] <= shift;
                            sda_oe        <= 1'b1;
                            reg_wr_stb    <= 1'b1;
                            reg_addr      <= pointer;
                            reg_wdata     <= shift;
                            if (pointer == 4'd0) begin
                                spi_stb    <= 1'b1;
                                spi_action <= shift;
                                spi_data   <= {regs[8], regs[7], regs[6]};
                            end
                            pointer <= pointer + 4'd1;
                            state   <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        // The pointer advances after every byte sent, so it is also advanced
                        // after a NACK and ends one past the last byte the master read.
                        if (byte_done) begin
                            sda_oe   <= 1'b0;
                            pointer  <= pointer + 4'd1;
                            ack_seen <= 1'b0;
                            state    <= RACK;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            sda_oe   <= ~out_byte[6];
                            out_byte <= {out_byte[6:0], 1'b0};
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                ack_seen <= 1'b1;
                                out_byte <= regs[pointer];
                            end else begin
                                state <= IDLE;
                            end
                        end else if (scl_fall && ack_seen) begin
                            sda_oe   <= ~out_byte[7];
                            bit_cnt  <= 4'd0;
                            ack_seen <= 1'b0;
                            state    <= RDATA;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
